// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/WB with illegal-instruction and fetch-timeout traps.
// Latency: 4 cycles per instruction minimum (one per state); back-to-back throughput 1 instr / 4 cycles.
// Backpressure: FETCH holds imem_req until imem_ack or timeout; TRAP is sticky until rst_n.
module cpu_ctrl_fsm #(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [2:0]  instr_type,
    output logic        alu_en,
    output logic        sel_imm,
    output logic        sel_upper,
    output logic        reg_we,
    output logic        pc_en,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] retired_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b111
    } state_t;

    localparam logic [7:0] FETCH_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     st;
    logic [7:0] fcnt;
    logic [2:0] type_q;
    logic       legal;

    assign legal = (instr_type == 3'b000) || (instr_type == 3'b001) || (instr_type == 3'b010);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= S_IDLE;
            fcnt        <= 8'd0;
            type_q      <= 3'b000;
            imem_req    <= 1'b0;
            alu_en      <= 1'b0;
            reg_we      <= 1'b0;
            pc_en       <= 1'b0;
            halted      <= 1'b0;
            fault       <= 2'b00;
            retired_cnt <= 32'd0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them below.
            imem_req <= 1'b0;
            alu_en   <= 1'b0;
            reg_we   <= 1'b0;
            pc_en    <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (run) begin
                        st       <= S_FETCH;
                        fcnt     <= 8'd0;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        st <= S_DECODE;
                    end else if (fcnt == FETCH_LAST) begin
                        st     <= S_TRAP;
                        halted <= 1'b1;
                        fault  <= 2'b10;
                    end else begin
                        fcnt     <= fcnt + 8'd1;
                        imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    type_q <= instr_type;
                    if (legal) begin
                        st     <= S_EXEC;
                        alu_en <= 1'b1;
                    end else begin
                        st     <= S_TRAP;
                        halted <= 1'b1;
                        fault  <= 2'b01;
                    end
                end
                S_EXEC: begin
                    st          <= S_WB;
                    reg_we      <= 1'b1;
                    pc_en       <= 1'b1;
                    retired_cnt <= retired_cnt + 32'd1;
                end
                S_WB: begin
                    if (run) begin
                        st       <= S_FETCH;
                        fcnt     <= 8'd0;
                        imem_req <= 1'b1;
                    end else begin
                        st <= S_IDLE;
                    end
                end
                S_TRAP: begin
                    st <= S_TRAP;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

    // Operand selects follow the latched class; only meaningful while executing.
    assign sel_imm   = (st == S_EXEC) && (type_q == 3'b001);
    assign sel_upper = (st == S_EXEC) && (type_q == 3'b010);
    assign state     = st;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: per-scenario tasks with inline expected-value checks.
module tb_cpu_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic        imem_ack;
    logic [2:0]  instr_type;
    logic        alu_en;
    logic        sel_imm;
    logic        sel_upper;
    logic        reg_we;
    logic        pc_en;
    logic        halted;
    logic [1:0]  fault;
    logic [31:0] retired_cnt;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_ctrl_fsm #(.FETCH_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
        .instr_type(instr_type), .alu_en(alu_en), .sel_imm(sel_imm), .sel_upper(sel_upper),
        .reg_we(reg_we), .pc_en(pc_en), .halted(halted), .fault(fault),
        .retired_cnt(retired_cnt), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; instr_type = 3'b000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL reset_state: got %0b expected 000", state); end
        n_checks++; if ({imem_req, alu_en, sel_imm, sel_upper, reg_we, pc_en, halted} !== 7'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000000", {imem_req, alu_en, sel_imm, sel_upper, reg_we, pc_en, halted}); end
        n_checks++; if (fault !== 2'b00 || retired_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got fault=%0b ret=%0h expected 00/0", fault, retired_cnt); end
        // ack outside FETCH must not move the machine
        imem_ack = 1'b1;
        tick();
        n_checks++; if (state !== 3'b000 || imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_ack_ignored: got state=%0b req=%0b expected 000/0", state, imem_req); end
        imem_ack = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        run = 1'b1; imem_ack = 1'b1; instr_type = 3'b000;
        tick();
        n_checks++; if (state !== 3'b001 || imem_req !== 1'b1) begin n_fail++; $display("FAIL single_fetch: got state=%0b req=%0b expected 001/1", state, imem_req); end
        run = 1'b0;
        tick();
        n_checks++; if (state !== 3'b010 || imem_req !== 1'b0 || alu_en !== 1'b0) begin n_fail++; $display("FAIL single_decode: got state=%0b req=%0b alu=%0b expected 010/0/0", state, imem_req, alu_en); end
        imem_ack = 1'b0;
        tick();
        n_checks++; if (state !== 3'b011 || alu_en !== 1'b1 || sel_imm !== 1'b0 || sel_upper !== 1'b0 || reg_we !== 1'b0) begin n_fail++; $display("FAIL single_exec: got state=%0b alu=%0b imm=%0b up=%0b we=%0b expected 011/1/0/0/0", state, alu_en, sel_imm, sel_upper, reg_we); end
        tick();
        n_checks++; if (state !== 3'b100 || reg_we !== 1'b1 || pc_en !== 1'b1 || alu_en !== 1'b0 || retired_cnt !== 32'd1) begin n_fail++; $display("FAIL single_wb: got state=%0b we=%0b pc=%0b alu=%0b ret=%0h expected 100/1/1/0/1", state, reg_we, pc_en, alu_en, retired_cnt); end
        tick();
        n_checks++; if (state !== 3'b000 || reg_we !== 1'b0 || pc_en !== 1'b0 || retired_cnt !== 32'd1) begin n_fail++; $display("FAIL single_idle: got state=%0b we=%0b pc=%0b ret=%0h expected 000/0/0/1", state, reg_we, pc_en, retired_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] types [3];
        types = '{3'b001, 3'b010, 3'b000};
        apply_reset();
        run = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (state !== 3'b001 || imem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_fetch%0d: got state=%0b req=%0b expected 001/1", i, state, imem_req); end
            instr_type = types[i];
            tick();
            tick();
            n_checks++; if (state !== 3'b011 || alu_en !== 1'b1 || sel_imm !== (i == 0) || sel_upper !== (i == 1)) begin n_fail++; $display("FAIL b2b_exec%0d: got state=%0b alu=%0b imm=%0b up=%0b expected 011/1/%0b/%0b", i, state, alu_en, sel_imm, sel_upper, i == 0, i == 1); end
            tick();
            n_checks++; if (state !== 3'b100 || reg_we !== 1'b1 || sel_imm !== 1'b0 || sel_upper !== 1'b0 || retired_cnt !== 32'(i + 1)) begin n_fail++; $display("FAIL b2b_wb%0d: got state=%0b we=%0b imm=%0b up=%0b ret=%0h expected 100/1/0/0/%0h", i, state, reg_we, sel_imm, sel_upper, retired_cnt, i + 1); end
            if (i == 2) run = 1'b0;
        end
        tick();
        n_checks++; if (state !== 3'b000 || retired_cnt !== 32'd3) begin n_fail++; $display("FAIL b2b_end: got state=%0b ret=%0h expected 000/3", state, retired_cnt); end
    endtask

    task automatic test_illegal(input logic [2:0] t);
        apply_reset();
        run = 1'b1; imem_ack = 1'b1; instr_type = t;
        tick();
        tick();
        tick();
        n_checks++; if (state !== 3'b111 || halted !== 1'b1 || fault !== 2'b01 || alu_en !== 1'b0 || retired_cnt !== 32'd0) begin n_fail++; $display("FAIL illegal_%0b_trap: got state=%0b halt=%0b fault=%0b alu=%0b ret=%0h expected 111/1/01/0/0", t, state, halted, fault, alu_en, retired_cnt); end
        for (int k = 0; k < 4; k++) begin
            run = ~run;
            tick();
        end
        n_checks++; if (state !== 3'b111 || halted !== 1'b1 || fault !== 2'b01 || imem_req !== 1'b0 || reg_we !== 1'b0 || retired_cnt !== 32'd0) begin n_fail++; $display("FAIL illegal_%0b_sticky: got state=%0b halt=%0b fault=%0b req=%0b we=%0b ret=%0h expected 111/1/01/0/0/0", t, state, halted, fault, imem_req, reg_we, retired_cnt); end
    endtask

    task automatic test_timeout();
        int req_low;
        apply_reset();
        run = 1'b1; imem_ack = 1'b0;
        req_low = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (state !== 3'b001 || imem_req !== 1'b1) req_low++;
            run = 1'b0;
        end
        n_checks++; if (req_low !== 0) begin n_fail++; $display("FAIL timeout_hold: got %0d bad fetch cycles expected 0", req_low); end
        tick();
        n_checks++; if (state !== 3'b111 || fault !== 2'b10 || halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_trap: got state=%0b fault=%0b halt=%0b req=%0b expected 111/10/1/0", state, fault, halted, imem_req); end
        // ack arriving on the last permitted cycle beats the timeout
        apply_reset();
        run = 1'b1; imem_ack = 1'b0; instr_type = 3'b000;
        tick();
        for (int k = 2; k <= 16; k++) tick();
        n_checks++; if (state !== 3'b001) begin n_fail++; $display("FAIL timeout_cycle16: got state=%0b expected 001", state); end
        imem_ack = 1'b1;
        tick();
        n_checks++; if (state !== 3'b010 || fault !== 2'b00 || halted !== 1'b0) begin n_fail++; $display("FAIL timeout_ack_wins: got state=%0b fault=%0b halt=%0b expected 010/00/0", state, fault, halted); end
        imem_ack = 1'b0; run = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        force dut.retired_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt;
        run = 1'b1; imem_ack = 1'b1; instr_type = 3'b001;
        tick();
        run = 1'b0;
        tick();
        tick();
        n_checks++; if (retired_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pre: got %0h expected ffffffff", retired_cnt); end
        tick();
        n_checks++; if (state !== 3'b100 || retired_cnt !== 32'h0 || fault !== 2'b00 || reg_we !== 1'b1) begin n_fail++; $display("FAIL wrap_post: got state=%0b ret=%0h fault=%0b we=%0b expected 100/0/00/1", state, retired_cnt, fault, reg_we); end
        imem_ack = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        run = 1'b1; imem_ack = 1'b1; instr_type = 3'b001;
        tick();
        tick();
        tick();
        n_checks++; if (state !== 3'b011 || alu_en !== 1'b1 || sel_imm !== 1'b1) begin n_fail++; $display("FAIL arst_pre_exec: got state=%0b alu=%0b imm=%0b expected 011/1/1", state, alu_en, sel_imm); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 3'b000 || alu_en !== 1'b0 || sel_imm !== 1'b0 || reg_we !== 1'b0 || retired_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_immediate: got state=%0b alu=%0b imm=%0b we=%0b ret=%0h expected 000/0/0/0/0", state, alu_en, sel_imm, reg_we, retired_cnt); end
        tick();
        n_checks++; if (reg_we !== 1'b0 || pc_en !== 1'b0 || retired_cnt !== 32'd0 || state !== 3'b000) begin n_fail++; $display("FAIL arst_no_wb: got we=%0b pc=%0b ret=%0h state=%0b expected 0/0/0/000", reg_we, pc_en, retired_cnt, state); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (state !== 3'b001) begin n_fail++; $display("FAIL arst_restart: got state=%0b expected 001", state); end
        run = 1'b0; imem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; instr_type = 3'b000;
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal(3'b111);
        test_illegal(3'b101);
        test_timeout();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
